// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Contents: fetch_state_t (FSM encoding), INSTR_BYTES (bytes per
// instruction word), PC_STEP (sequential PC increment).
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Collects instruction bytes big-endian into a 32-bit word.
// Only the first three bytes are stored; the fourth is taken straight
// from i_byte so the finished word is available in the same cycle the
// last byte arrives (o_done).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     restart assembly (discard stored bytes)
//   i_shift     i_byte is a valid instruction byte this cycle
//   i_byte      byte from instruction memory
//   o_word      {stored bytes, i_byte}, byte0 in [31:24]
//   o_done      the byte being shifted completes the word
module fetch_byte_assembler
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_done
);

  logic [23:0] r_sr;
  logic [1:0]  r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_sr    <= {r_sr[15:0], i_byte};
      r_count <= r_count + 2'd1;
    end
  end

  assign o_word = {r_sr, i_byte};
  assign o_done = i_shift && (r_count == 2'(INSTR_BYTES - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads four bytes per
// instruction from a 256x8 synchronous-read memory, and hands the
// assembled word to decode over a valid/ready handshake. Redirects from
// execute abort any partial fetch.
// Optional build macro: FETCH_ALIGN_CHECK_EN -- misaligned redirect
// targets park the sequencer in FAULT with fetch_fault=1 until an
// aligned redirect arrives. Undefined: fetch_fault is tied 0.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   redirect_valid/_addr        branch/jump target from execute
//   mem_rd_en/mem_addr/mem_rdata  instruction memory read port
//   instr_valid/instr_ready     handshake to decode
//   instr_data/instr_pc/instr_pc_plus4  instruction and its address
//   fetch_fault                 misaligned redirect flag
//
// state | meaning
// FETCH | cnt 0..3 issue byte reads, cnt 1..4 collect bytes, cnt 4 load
// VALID | instruction held for decode until instr_ready
// FAULT | misaligned redirect seen (FETCH_ALIGN_CHECK_EN builds only)
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc,
  output logic [31:0]       instr_pc_plus4,
  output logic              fetch_fault
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [2:0]   r_cnt, w_cnt_nxt;
  logic         r_instr_valid, w_valid_nxt;
  logic [31:0]  r_instr_data;
  logic [31:0]  r_instr_pc;
  logic         w_load;
  logic         w_rd_en;
  logic         w_shift;
  logic         w_clear;
  logic [31:0]  w_word;
  logic         w_done;

  // Kept outside the next-state block so the assembler's done flag does
  // not form a combinational loop back through it.
  assign w_shift = (r_state == FETCH) && (r_cnt != 3'd0) && !redirect_valid;
  assign w_clear = redirect_valid || ((r_state == FETCH) && (r_cnt == 3'd0));

  fetch_byte_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_shift (w_shift),
    .i_byte  (mem_rdata),
    .o_word  (w_word),
    .o_done  (w_done)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault, w_fault_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_instr_valid;
    w_load      = 1'b0;
    w_rd_en     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_fault_nxt = r_fault;
`endif
    unique case (r_state)
      FETCH: begin
        w_rd_en = (r_cnt < 3'(INSTR_BYTES));
        if (w_done) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = VALID;
        end else if (r_cnt < 3'(INSTR_BYTES)) begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      VALID: begin
        if (instr_ready) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        // FAULT: idle until redirected.
      end
    endcase

    // Redirect overrides everything; a coincident handshake still
    // completes since instr_valid drops and decode has taken the word.
    if (redirect_valid) begin
      w_pc_nxt    = redirect_addr;
      w_cnt_nxt   = 3'd0;
      w_valid_nxt = 1'b0;
      w_load      = 1'b0;
      w_state_nxt = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_addr[1:0] != 2'b00) begin
        w_state_nxt = FAULT;
        w_fault_nxt = 1'b1;
      end else begin
        w_fault_nxt = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_cnt         <= 3'd0;
      r_instr_valid <= 1'b0;
      r_instr_data  <= 32'd0;
      r_instr_pc    <= RESET_PC;
    end else begin
      r_pc          <= w_pc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_instr_valid <= w_valid_nxt;
      if (w_load) begin
        r_instr_data <= w_word;
        r_instr_pc   <= r_pc;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else        r_fault <= w_fault_nxt;
  end
  assign fetch_fault = r_fault;
`else
  assign fetch_fault = 1'b0;
`endif

  // Gated with rst_n so no strobe escapes while reset is held.
  assign mem_rd_en      = rst_n && w_rd_en;
  assign mem_addr       = r_pc[ADDR_W-1:0] + ADDR_W'(r_cnt);
  assign instr_valid    = r_instr_valid;
  assign instr_data     = r_instr_data;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc + PC_STEP;

endmodule
